sd_sector_client: RTL
=====================

Name: sd_sector_client

Overview:
- Initiator side of the MiST sector interface (sd_lba / sd_rd / sd_wr / sd_ack / sd_buff_*).
- Accepts single-sector read/write commands from the floppy controller and drives the request/ack handshake toward the I/O controller.
- Holds the sector in a local 512-byte dual-port buffer and exposes that buffer to the controller as a byte-addressed port.
- Sits between the tatung FDC logic and the mist_io block, in the clk_sys domain.

Parameters:
- ACK_TIMEOUT, 24'd8000000, clk_sys cycles to wait for sd_ack rising before aborting (0 = never time out).
- SECTOR_SHIFT, 9, log2 of sector size; the buffer depth is 1<<SECTOR_SHIFT.

Ports:
- Clocking and reset: one clock; reset is synchronous and active-high.
- clk_sys  in  1  system clock (32 MHz).
- reset  in  1  synchronous active-high reset.
- Image and command side:
- img_mounted  in  1  pulse on a new image mount.
- img_size  in  64  image size in bytes, valid with img_mounted.
- img_present  out  1  a non-empty image is mounted.
- req_lba  in  32  sector number, sampled with req_rd/req_wr.
- req_rd  in  1  1-cycle read command.
- req_wr  in  1  1-cycle write command.
- busy  out  1  command in progress.
- done  out  1  1-cycle completion pulse.
- err  out  1  status of the last command, valid from done until the next command.
- Controller byte port:
- buf_addr  in  9  controller byte address.
- buf_din  in  8  controller write data.
- buf_we  in  1  controller byte write.
- buf_dout  out  8  controller read data.
- I/O controller side:
- sd_lba  out  32  sector address to the I/O controller.
- sd_rd  out  1  read request.
- sd_wr  out  1  write request.
- sd_ack  in  1  I/O controller transfer in progress.
- sd_buff_addr  in  9  buffer address from the I/O controller.
- sd_buff_dout  in  8  read data from the I/O controller.
- sd_buff_din  out  8  write data to the I/O controller.
- sd_buff_wr  in  1  byte strobe for sd_buff_dout.

Behaviour:
- Reset values: all outputs 0, sector_count 0, state IDLE. Buffer contents are undefined.
- Mount handling:
  - On img_mounted, latch sector_count = img_size >> SECTOR_SHIFT (saturates at 32'hFFFFFFFF).
  - img_present = (sector_count != 0), registered.
  - A mount during a command does not abort the command; the new count applies to the next command.
- Buffer:
  - 512x8 true dual-port RAM.
  - Port A (controller): buf_dout = mem[buf_addr] with 1-cycle latency. buf_we writes only when busy=0; it is ignored while busy.
  - Port B (I/O controller): during a READ in XFER, sd_buff_wr writes sd_buff_dout to mem[sd_buff_addr]. sd_buff_din = mem[sd_buff_addr], 1-cycle registered latency, at all times.
- FSM states: IDLE, REQ, XFER, FIN.
- IDLE:
  - On req_rd or req_wr, latch op and lba, and set busy=1.
  - If both req_rd and req_wr are high, the read wins.
  - If img_present=0 or lba >= sector_count, go to FIN with err=1 and no request issued.
  - Otherwise set sd_lba=lba, assert sd_rd or sd_wr, clear the timeout counter, and go to REQ.
  - The cycle after the command, busy=1 and sd_rd/sd_wr=1 (registered).
- REQ:
  - Hold sd_rd/sd_wr and sd_lba stable.
  - On sd_ack=1, deassert sd_rd/sd_wr the same edge and go to XFER.
  - If the counter reaches ACK_TIMEOUT, deassert the request and go to FIN with err=1.
- XFER:
  - On sd_ack falling (1->0), go to FIN with err=0.
  - No byte count check is made; a short transfer is accepted.
- FIN: done=1 for one cycle, busy=0 the following cycle, return to IDLE.
- New commands are ignored while busy=1 (no queueing).
- sd_ack already high in IDLE (stale transfer) is ignored; REQ needs sd_ack high while in REQ, and the state is entered with sd_ack low only if the ack has fallen.
  - Implementation: REQ first waits for sd_ack=0 before accepting a rising edge.
- Reset mid-operation: sd_rd/sd_wr drop on the next edge and the state goes to IDLE. A later sd_ack/sd_buff_wr still updates the RAM in READ context only if the state is XFER, so post-reset strobes are discarded.
- Timeout counter: 24 bits, saturating.

Test Plan:
- Mount img_size=737280 (1440 sectors), req_rd lba=5 → sd_rd=1 and sd_lba=5 next cycle. Bench acks 4 cycles later and streams 512 bytes (addr i, data i^8'h5A), then drops ack → one done pulse, err=0. Controller reads addr 3 → 8'h59 after 1 cycle.
- Controller writes addr 0..511 = ~addr[7:0], then req_wr lba=1439 → sd_wr asserted. Bench reads sd_buff_addr=10 → sd_buff_din=8'hF5 one cycle later, done err=0.
- req_rd lba=1440 (one past end) → no sd_rd ever asserted, done 2 cycles after command, err=1. The same with no image mounted → err=1, img_present=0.
- req_rd and req_wr in the same cycle → only sd_rd asserted. A second req_rd while busy is ignored: sd_lba unchanged and exactly one done.
- ACK_TIMEOUT=16, no ack → sd_rd held 16 cycles, then dropped, done with err=1, busy=0.
- Reset asserted mid-XFER after 100 bytes → sd_rd=0, busy=0, done=0. Remaining sd_buff_wr strobes leave the RAM unchanged, checked by a controller read.

Source files
------------

// File: rtl/sd_sector_client.sv
// Initiator side of the MiST sector interface: single-sector read/write commands,
// sd_rd/sd_wr/sd_ack handshake, and a local sector buffer shared with the controller.
module sd_sector_client #(
    parameter logic [23:0] ACK_TIMEOUT  = 24'd8000000,
    parameter int unsigned SECTOR_SHIFT = 9
) (
    input  logic                    clk_sys,
    input  logic                    reset,
    input  logic                    img_mounted,
    input  logic [63:0]             img_size,
    output logic                    img_present,
    input  logic [31:0]             req_lba,
    input  logic                    req_rd,
    input  logic                    req_wr,
    output logic                    busy,
    output logic                    done,
    output logic                    err,
    input  logic [SECTOR_SHIFT-1:0] buf_addr,
    input  logic [7:0]              buf_din,
    input  logic                    buf_we,
    output logic [7:0]              buf_dout,
    output logic [31:0]             sd_lba,
    output logic                    sd_rd,
    output logic                    sd_wr,
    input  logic                    sd_ack,
    input  logic [SECTOR_SHIFT-1:0] sd_buff_addr,
    input  logic [7:0]              sd_buff_dout,
    output logic [7:0]              sd_buff_din,
    input  logic                    sd_buff_wr
);

    localparam int unsigned DEPTH = 1 << SECTOR_SHIFT;

    typedef enum logic [1:0] {IDLE, REQ, XFER, FIN} state_t;

    state_t      state_q;
    logic [31:0] sector_cnt_q, sector_cnt_d;
    logic        img_present_q;
    logic        busy_q, done_q, err_q;
    logic        sd_rd_q, sd_wr_q;
    logic [31:0] sd_lba_q;
    logic        op_wr_q;
    logic        ack_prev_q;
    logic [23:0] tmo_q;
    logic        tmo_hit;
    logic [63:0] size_sectors;
    logic [7:0]  buf_dout_q, sd_buff_din_q;
    logic [7:0]  mem [DEPTH];

    always_comb begin
        size_sectors = img_size >> SECTOR_SHIFT;
        sector_cnt_d = (|size_sectors[63:32]) ? '1 : size_sectors[31:0];
        tmo_hit      = (ACK_TIMEOUT != '0) &&
                       (({1'b0, tmo_q} + 25'd1) >= {1'b0, ACK_TIMEOUT});
    end

    // busy stays high through the cycle after done, so IDLE clears it before accepting work
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_q       <= IDLE;
            sector_cnt_q  <= '0;
            img_present_q <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            err_q         <= 1'b0;
            sd_rd_q       <= 1'b0;
            sd_wr_q       <= 1'b0;
            sd_lba_q      <= '0;
            op_wr_q       <= 1'b0;
            ack_prev_q    <= 1'b0;
            tmo_q         <= '0;
        end else begin
            ack_prev_q <= sd_ack;
            done_q     <= 1'b0;
            if (img_mounted) begin
                sector_cnt_q  <= sector_cnt_d;
                img_present_q <= (sector_cnt_d != '0);
            end
            case (state_q)
                IDLE: begin
                    if (busy_q) begin
                        busy_q <= 1'b0;
                    end else if (req_rd || req_wr) begin
                        busy_q  <= 1'b1;
                        op_wr_q <= !req_rd;
                        if (!img_present_q || (req_lba >= sector_cnt_q)) begin
                            err_q   <= 1'b1;
                            state_q <= FIN;
                        end else begin
                            err_q    <= 1'b0;
                            sd_lba_q <= req_lba;
                            sd_rd_q  <= req_rd;
                            sd_wr_q  <= !req_rd;
                            tmo_q    <= '0;
                            state_q  <= REQ;
                        end
                    end
                end
                REQ: begin
                    // only a fresh rising ack counts; a stale high ack must fall first
                    if (sd_ack && !ack_prev_q) begin
                        sd_rd_q <= 1'b0;
                        sd_wr_q <= 1'b0;
                        state_q <= XFER;
                    end else if (tmo_hit) begin
                        sd_rd_q <= 1'b0;
                        sd_wr_q <= 1'b0;
                        err_q   <= 1'b1;
                        state_q <= FIN;
                    end else if (tmo_q != '1) begin
                        tmo_q <= tmo_q + 24'd1;
                    end
                end
                XFER: begin
                    if (!sd_ack && ack_prev_q) begin
                        state_q <= FIN;
                    end
                end
                FIN: begin
                    done_q  <= 1'b1;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_sys) begin
        if (buf_we && !busy_q) begin
            mem[buf_addr] <= buf_din;
        end
        if (!reset && (state_q == XFER) && !op_wr_q && sd_buff_wr) begin
            mem[sd_buff_addr] <= sd_buff_dout;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            buf_dout_q    <= '0;
            sd_buff_din_q <= '0;
        end else begin
            buf_dout_q    <= mem[buf_addr];
            sd_buff_din_q <= mem[sd_buff_addr];
        end
    end

    assign img_present = img_present_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign err         = err_q;
    assign sd_lba      = sd_lba_q;
    assign sd_rd       = sd_rd_q;
    assign sd_wr       = sd_wr_q;
    assign buf_dout    = buf_dout_q;
    assign sd_buff_din = sd_buff_din_q;

endmodule
